// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bus between the multi-cycle control FSM and the MIPS datapath.
// Ports: decode inputs (opcode/funct/br_taken/mem_ack) and all control strobes.
interface mc_ctrl_if #(
    parameter int ALU_OP_W = 4
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                br_taken;
    logic                mem_ack;
    logic                ir_we;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic                grf_we;
    logic [1:0]          grf_wsel;
    logic [1:0]          grf_dsel;
    logic                alu_srcb;
    logic                imm_sext;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_req;
    logic                mem_we;
    logic                instr_done;
    logic [1:0]          err;
    logic [2:0]          state;
    logic [31:0]         cycle_cnt;
    logic [31:0]         instr_cnt;

    modport master (
        input  opcode, funct, br_taken, mem_ack,
        output ir_we, pc_we, pc_src, grf_we, grf_wsel, grf_dsel,
        output alu_srcb, imm_sext, alu_op, mem_req, mem_we,
        output instr_done, err, state, cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, funct, br_taken, mem_ack,
        input  ir_we, pc_we, pc_src, grf_we, grf_wsel, grf_dsel,
        input  alu_srcb, imm_sext, alu_op, mem_req, mem_we,
        input  instr_done, err, state, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/ERR).
// Ports: clk, reset (async active-low), bus (mc_ctrl_if.master).
// Optional MC_PERF_CNT_EN enables the cycle/instruction counters.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int ALU_OP_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    mc_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait;
    logic [1:0] r_err;

    logic w_rt, w_addu, w_subu, w_jr, w_nop;
    logic w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic w_alu, w_mem, w_ctl;
    logic w_srcb, w_sext;
    logic [ALU_OP_W-1:0] w_aluop;
    logic w_done;

    assign w_rt   = (bus.opcode == 6'h00);
    assign w_addu = w_rt && (bus.funct == 6'h21);
    assign w_subu = w_rt && (bus.funct == 6'h23);
    assign w_jr   = w_rt && (bus.funct == 6'h08);
    assign w_nop  = w_rt && (bus.funct == 6'h00);
    assign w_ori  = (bus.opcode == 6'h0d);
    assign w_lui  = (bus.opcode == 6'h0f);
    assign w_lw   = (bus.opcode == 6'h23);
    assign w_sw   = (bus.opcode == 6'h2b);
    assign w_beq  = (bus.opcode == 6'h04);
    assign w_j    = (bus.opcode == 6'h02);
    assign w_jal  = (bus.opcode == 6'h03);

    assign w_alu = w_addu | w_subu | w_nop | w_ori | w_lui;
    assign w_mem = w_lw | w_sw;
    assign w_ctl = w_j | w_jal | w_jr | w_beq;

    assign w_srcb = w_ori | w_lui | w_mem;
    assign w_sext = w_mem;

    always_comb begin
        w_aluop = ALU_OP_W'(0);
        if (w_subu) w_aluop = ALU_OP_W'(1);
        if (w_ori)  w_aluop = ALU_OP_W'(2);
        if (w_lui)  w_aluop = ALU_OP_W'(3);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_wait  <= 8'd0;
            r_err   <= 2'd0;
        end else begin
            unique case (r_state)
                FETCH:  r_state <= DECODE;
                DECODE: begin
                    if (w_ctl) begin
                        r_state <= FETCH;
                    end else if (w_alu || w_mem) begin
                        r_state <= EXEC;
                    end else begin
                        r_state <= ERR;
                        r_err   <= 2'd1;
                    end
                end
                EXEC: begin
                    if (w_mem) begin
                        r_state <= MEM;
                        r_wait  <= 8'd0;
                    end else begin
                        r_state <= WB;
                    end
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        r_state <= w_sw ? FETCH : WB;
                    end else if (r_wait == TMO_LAST) begin
                        r_state <= ERR;
                        r_err   <= 2'd2;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                WB:     r_state <= FETCH;
                ERR:    r_state <= ERR;
                default: r_state <= ERR;
            endcase
        end
    end

    // Strobes decode straight from state so a same-cycle mem_ack
    // and an asserted reset both take effect without a clock edge.
    always_comb begin
        bus.ir_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_src   = 2'd0;
        bus.grf_we   = 1'b0;
        bus.grf_wsel = 2'd0;
        bus.grf_dsel = 2'd0;
        bus.alu_srcb = 1'b0;
        bus.imm_sext = 1'b0;
        bus.alu_op   = ALU_OP_W'(0);
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        w_done       = 1'b0;
        if (reset) begin
            unique case (r_state)
                FETCH: bus.ir_we = 1'b1;
                DECODE: begin
                    unique case (1'b1)
                        w_j: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = 2'd2;
                            w_done     = 1'b1;
                        end
                        w_jal: begin
                            bus.pc_we    = 1'b1;
                            bus.pc_src   = 2'd2;
                            bus.grf_we   = 1'b1;
                            bus.grf_wsel = 2'd2;
                            bus.grf_dsel = 2'd2;
                            w_done       = 1'b1;
                        end
                        w_jr: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = 2'd3;
                            w_done     = 1'b1;
                        end
                        w_beq: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = bus.br_taken ? 2'd1 : 2'd0;
                            w_done     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                EXEC: begin
                    bus.alu_srcb = w_srcb;
                    bus.imm_sext = w_sext;
                    bus.alu_op   = w_aluop;
                end
                MEM: begin
                    bus.alu_srcb = w_srcb;
                    bus.imm_sext = w_sext;
                    bus.alu_op   = w_aluop;
                    bus.mem_req  = 1'b1;
                    bus.mem_we   = w_sw;
                    if (bus.mem_ack && w_sw) begin
                        bus.pc_we = 1'b1;
                        w_done    = 1'b1;
                    end
                end
                WB: begin
                    bus.alu_srcb = w_srcb;
                    bus.imm_sext = w_sext;
                    bus.alu_op   = w_aluop;
                    // sll $0 is the nop: no register write.
                    bus.grf_we   = !w_nop;
                    bus.grf_wsel = w_rt ? 2'd0 : 2'd1;
                    bus.grf_dsel = w_lw ? 2'd1 : 2'd0;
                    bus.pc_we    = 1'b1;
                    w_done       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_done = w_done;
    assign bus.err        = r_err;
    assign bus.state      = r_state;

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_cyc;
    logic [31:0] r_icnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc  <= 32'd0;
            r_icnt <= 32'd0;
        end else begin
            if (r_state != ERR) r_cyc <= r_cyc + 32'd1;
            if (w_done) r_icnt <= r_icnt + 32'd1;
        end
    end

    assign bus.cycle_cnt = r_cyc;
    assign bus.instr_cnt = r_icnt;
`else
    assign bus.cycle_cnt = 32'd0;
    assign bus.instr_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl.
// Stimulus queues per-cycle expectations; a negedge monitor compares.
module tb_mc_ctrl;
    logic clk;
    logic reset;

    mc_ctrl_if #(.ALU_OP_W(4)) bus ();

    mc_ctrl #(.MEM_TIMEOUT(15), .ALU_OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

`ifdef MC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [22:0] v;
        logic [31:0] cc;
        logic [31:0] ic;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_bad;
    int   m_cc;
    int   m_ic;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t        e;
        logic [22:0] got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {bus.ir_we, bus.pc_we, bus.pc_src, bus.grf_we,
                   bus.grf_wsel, bus.grf_dsel, bus.alu_srcb,
                   bus.imm_sext, bus.alu_op, bus.mem_req, bus.mem_we,
                   bus.instr_done, bus.err, bus.state};
            n_chk++;
            if (got !== e.v) begin
                n_bad++;
                $display("FAIL %s ctl got=%h exp=%h", e.name, got, e.v);
            end
            n_chk++;
            if (bus.cycle_cnt !== e.cc || bus.instr_cnt !== e.ic) begin
                n_bad++;
                $display("FAIL %s cnt got=%0d/%0d exp=%0d/%0d", e.name,
                         bus.cycle_cnt, bus.instr_cnt, e.cc, e.ic);
            end
        end
    end

    task automatic step(
        input string nm, input logic [2:0] st,
        input logic ir, input logic pw, input logic [1:0] ps,
        input logic gw, input logic [1:0] ws, input logic [1:0] ds,
        input logic sb, input logic sx, input logic [3:0] op,
        input logic mr, input logic mw, input logic dn,
        input logic [1:0] er
    );
        exp_t e;
        if (!reset) begin
            m_cc = 0;
            m_ic = 0;
        end
        e.name = nm;
        e.v    = {ir, pw, ps, gw, ws, ds, sb, sx, op, mr, mw, dn, er, st};
        e.cc   = PERF ? 32'(m_cc) : 32'd0;
        e.ic   = PERF ? 32'(m_ic) : 32'd0;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (reset) begin
            if (st != 3'd5) m_cc++;
            if (dn) m_ic++;
        end
    endtask

    task automatic zero(input string nm);
        step(nm, 0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0);
    endtask

    task automatic fet(input string nm);
        step(nm, 0, 1,0,0, 0,0,0, 0,0,0, 0,0,0, 0);
    endtask

    task automatic dec0(input string nm);
        step(nm, 1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0);
    endtask

    task automatic ex(input string nm, input logic sb, input logic sx,
                      input logic [3:0] op);
        step(nm, 2, 0,0,0, 0,0,0, sb,sx,op, 0,0,0, 0);
    endtask

    task automatic mem(input string nm, input logic mw, input logic dn);
        step(nm, 3, 0,dn,0, 0,0,0, 1,1,0, 1,mw,dn, 0);
    endtask

    task automatic errst(input string nm, input logic [1:0] er);
        step(nm, 5, 0,0,0, 0,0,0, 0,0,0, 0,0,0, er);
    endtask

    task automatic ins(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    task automatic alu_i(input string nm, input logic [5:0] op,
                         input logic [5:0] fn, input logic sb,
                         input logic sx, input logic [3:0] aop,
                         input logic gw, input logic [1:0] ws);
        ins(op, fn);
        fet({nm, "_f"});
        dec0({nm, "_d"});
        ex({nm, "_e"}, sb, sx, aop);
        step({nm, "_w"}, 4, 0,1,0, gw,ws,0, sb,sx,aop, 0,0,1, 0);
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b0;
        zero(nm);
        reset = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        m_cc  = 0;
        m_ic  = 0;
        reset = 1'b0;
        bus.opcode   = 6'h00;
        bus.funct    = 6'h00;
        bus.br_taken = 1'b0;
        bus.mem_ack  = 1'b0;
        @(posedge clk);
        #1;
        zero("rst0");
        zero("rst1");
        reset = 1'b1;

        alu_i("addu0", 6'h00, 6'h21, 0, 0, 0, 1, 0);
        alu_i("addu1", 6'h00, 6'h21, 0, 0, 0, 1, 0);
        alu_i("addu2", 6'h00, 6'h21, 0, 0, 0, 1, 0);
        alu_i("subu",  6'h00, 6'h23, 0, 0, 1, 1, 0);
        alu_i("ori",   6'h0d, 6'h34, 1, 0, 2, 1, 1);
        alu_i("lui",   6'h0f, 6'h00, 1, 0, 3, 1, 1);
        alu_i("nop",   6'h00, 6'h00, 0, 0, 0, 0, 0);

        ins(6'h23, 6'h00);
        fet("lw_f");
        dec0("lw_d");
        ex("lw_e", 1, 1, 0);
        mem("lw_m0", 0, 0);
        mem("lw_m1", 0, 0);
        bus.mem_ack = 1'b1;
        mem("lw_m2", 0, 0);
        bus.mem_ack = 1'b0;
        step("lw_w", 4, 0,1,0, 1,1,1, 1,1,0, 0,0,1, 0);

        ins(6'h2b, 6'h00);
        fet("sw_f");
        dec0("sw_d");
        ex("sw_e", 1, 1, 0);
        bus.mem_ack = 1'b1;
        mem("sw_m", 1, 1);
        bus.mem_ack = 1'b0;

        ins(6'h04, 6'h00);
        bus.br_taken = 1'b1;
        fet("beqt_f");
        step("beqt_d", 1, 0,1,1, 0,0,0, 0,0,0, 0,0,1, 0);
        bus.br_taken = 1'b0;
        fet("beqn_f");
        step("beqn_d", 1, 0,1,0, 0,0,0, 0,0,0, 0,0,1, 0);

        ins(6'h02, 6'h00);
        fet("j_f");
        step("j_d", 1, 0,1,2, 0,0,0, 0,0,0, 0,0,1, 0);
        ins(6'h03, 6'h00);
        fet("jal_f");
        step("jal_d", 1, 0,1,2, 1,2,2, 0,0,0, 0,0,1, 0);
        ins(6'h00, 6'h08);
        fet("jr_f");
        step("jr_d", 1, 0,1,3, 0,0,0, 0,0,0, 0,0,1, 0);

        ins(6'h00, 6'h2a);
        fet("ilr_f");
        dec0("ilr_d");
        errst("ilr_x0", 1);
        errst("ilr_x1", 1);
        do_reset("ilr_rst");

        ins(6'h3f, 6'h00);
        fet("il3f_f");
        dec0("il3f_d");
        errst("il3f_x0", 1);
        errst("il3f_x1", 1);
        do_reset("il3f_rst");

        ins(6'h2b, 6'h00);
        fet("to_f");
        dec0("to_d");
        ex("to_e", 1, 1, 0);
        for (int i = 0; i < 15; i++) mem("to_m", 1, 0);
        errst("to_x0", 2);
        errst("to_x1", 2);
        do_reset("to_rst");

        ins(6'h23, 6'h00);
        fet("rm_f");
        dec0("rm_d");
        ex("rm_e", 1, 1, 0);
        mem("rm_m", 0, 0);
        reset = 1'b0;
        zero("rm_rst");
        reset = 1'b1;
        fet("rm_post");
        dec0("rm_d2");
        ex("rm_e2", 1, 1, 0);
        bus.mem_ack = 1'b1;
        mem("rm_m2", 0, 0);
        bus.mem_ack = 1'b0;
        step("rm_w2", 4, 0,1,0, 1,1,1, 1,1,0, 0,0,1, 0);

        alu_i("addu_end", 6'h00, 6'h21, 0, 0, 0, 1, 0);
        fet("end_f");

        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
